mips_multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS datapath. It is the producer side of the aluop interface: it decodes the instruction opcode, sequences fetch, decode, execute, memory and writeback steps, and drives the 4-bit aluop consumed by the ALU control decoder. It also drives every datapath mux select and write enable. Memory accesses use a ready handshake, so the FSM stalls on slow memory.

---
 rtl/mips_ctrl_pkg.sv | 152 +++++++++++++++
 rtl/mips_op_class.sv | 35 +++
 rtl/mips_multicycle_ctrl.sv | 103 ++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants, encodings and state type for the multicycle MIPS main control.
package mips_ctrl_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned ALUOP_W  = 4;
  localparam int unsigned SEL_W    = 2;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'd0;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'd2;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'd3;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'd4;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'd5;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'd8;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'd10;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'd12;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'd13;
  localparam logic [OPCODE_W-1:0] OP_XORI  = 6'd14;
  localparam logic [OPCODE_W-1:0] OP_LUI   = 6'd15;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'd35;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'd43;

  // aluop codes understood by the ALU control decoder
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 4'b0000;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 4'b0001;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 4'b0010;
  localparam logic [ALUOP_W-1:0] ALUOP_ANDI  = 4'b0011;
  localparam logic [ALUOP_W-1:0] ALUOP_LUI   = 4'b0100;
  localparam logic [ALUOP_W-1:0] ALUOP_SLTI  = 4'b0101;
  localparam logic [ALUOP_W-1:0] ALUOP_XORI  = 4'b0110;
  localparam logic [ALUOP_W-1:0] ALUOP_ORI   = 4'b0111;

  localparam logic [SEL_W-1:0] REG_DST_RT = 2'd0;
  localparam logic [SEL_W-1:0] REG_DST_RD = 2'd1;
  localparam logic [SEL_W-1:0] REG_DST_RA = 2'd2;

  localparam logic [SEL_W-1:0] M2R_ALUOUT = 2'd0;
  localparam logic [SEL_W-1:0] M2R_MDR    = 2'd1;
  localparam logic [SEL_W-1:0] M2R_PC     = 2'd2;

  localparam logic [SEL_W-1:0] ALU_B_REG     = 2'd0;
  localparam logic [SEL_W-1:0] ALU_B_FOUR    = 2'd1;
  localparam logic [SEL_W-1:0] ALU_B_IMM     = 2'd2;
  localparam logic [SEL_W-1:0] ALU_B_IMM_SL2 = 2'd3;

  localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_READ, ST_MEM_WB,
    ST_MEM_WRITE, ST_R_EXEC, ST_R_WB, ST_I_EXEC, ST_I_WB, ST_BRANCH,
    ST_JUMP, ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_MEM, CLS_R, CLS_BRANCH, CLS_JUMP, CLS_IMM, CLS_ILLEGAL
  } op_class_t;

  // Moore control word held in the output register
  typedef struct packed {
    logic               pc_write;
    logic               pc_write_cond;
    logic               pc_write_ncond;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic [SEL_W-1:0]   reg_dst;
    logic [SEL_W-1:0]   mem_to_reg;
    logic               reg_write;
    logic               alu_src_a;
    logic [SEL_W-1:0]   alu_src_b;
    logic [ALUOP_W-1:0] aluop;
    logic [SEL_W-1:0]   pc_source;
    logic               halted;
  } ctrl_t;

  // Control word asserted while the FSM sits in state s
  function automatic ctrl_t state_ctrl(input state_t s,
                                       input logic [ALUOP_W-1:0] imm_aluop,
                                       input logic is_bne,
                                       input logic is_jal);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = ALU_B_FOUR;
        c.aluop     = ALUOP_ADD;
        c.pc_source = PC_SRC_ALU;
      end
      ST_DECODE: c.alu_src_b = ALU_B_IMM_SL2;
      ST_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = ALU_B_IMM;
      end
      ST_MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = REG_DST_RT;
        c.mem_to_reg = M2R_MDR;
      end
      ST_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      ST_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = ALU_B_REG;
        c.aluop     = ALUOP_RTYPE;
      end
      ST_R_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = REG_DST_RD;
        c.mem_to_reg = M2R_ALUOUT;
      end
      ST_I_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = ALU_B_IMM;
        c.aluop     = imm_aluop;
      end
      ST_I_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = REG_DST_RT;
        c.mem_to_reg = M2R_ALUOUT;
      end
      ST_BRANCH: begin
        c.alu_src_a      = 1'b1;
        c.alu_src_b      = ALU_B_REG;
        c.aluop          = ALUOP_SUB;
        c.pc_source      = PC_SRC_ALUOUT;
        c.pc_write_cond  = ~is_bne;
        c.pc_write_ncond = is_bne;
      end
      ST_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PC_SRC_JUMP;
        if (is_jal) begin
          c.reg_write  = 1'b1;
          c.reg_dst    = REG_DST_RA;
          c.mem_to_reg = M2R_PC;
        end
      end
      ST_HALT: c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_op_class.sv
// Opcode classifier shared by the DECODE dispatch and the immediate-op aluop selection.
module mips_op_class
  import mips_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_t           op_class_c,
  output logic [ALUOP_W-1:0]  imm_aluop_c,
  output logic                is_bne_c,
  output logic                is_jal_c,
  output logic                legal_c
);

  // Map opcode to its instruction class and immediate aluop
  always_comb begin
    op_class_c  = CLS_ILLEGAL;
    imm_aluop_c = ALUOP_ADD;
    legal_c     = 1'b1;
    is_bne_c    = (opcode == OP_BNE);
    is_jal_c    = (opcode == OP_JAL);
    case (opcode)
      OP_LW, OP_SW:   op_class_c = CLS_MEM;
      OP_RTYPE:       op_class_c = CLS_R;
      OP_BEQ, OP_BNE: op_class_c = CLS_BRANCH;
      OP_J, OP_JAL:   op_class_c = CLS_JUMP;
      OP_ADDI: begin op_class_c = CLS_IMM; imm_aluop_c = ALUOP_ADD;  end
      OP_SLTI: begin op_class_c = CLS_IMM; imm_aluop_c = ALUOP_SLTI; end
      OP_ANDI: begin op_class_c = CLS_IMM; imm_aluop_c = ALUOP_ANDI; end
      OP_ORI:  begin op_class_c = CLS_IMM; imm_aluop_c = ALUOP_ORI;  end
      OP_XORI: begin op_class_c = CLS_IMM; imm_aluop_c = ALUOP_XORI; end
      OP_LUI:  begin op_class_c = CLS_IMM; imm_aluop_c = ALUOP_LUI;  end
      default: legal_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath with ready-handshaked memory.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
)(
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                pc_write_ncond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic [SEL_W-1:0]    reg_dst,
  output logic [SEL_W-1:0]    mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [SEL_W-1:0]    alu_src_b,
  output logic [ALUOP_W-1:0]  aluop,
  output logic [SEL_W-1:0]    pc_source,
  output logic                halted,
  output logic                illegal_op
);

  state_t             state, state_nxt;
  ctrl_t              ctrl_q;
  op_class_t          op_class;
  logic [ALUOP_W-1:0] imm_aluop;
  logic               is_bne, is_jal, legal;
  logic               fetch_done;

  mips_op_class u_op_class (
    .opcode      (opcode),
    .op_class_c  (op_class),
    .imm_aluop_c (imm_aluop),
    .is_bne_c    (is_bne),
    .is_jal_c    (is_jal),
    .legal_c     (legal)
  );

  // Next-state sequencing; memory states hold until mem_ready
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      state_nxt = ST_FETCH;
      ST_FETCH:     if (mem_ready) state_nxt = ST_DECODE;
      ST_DECODE: begin
        case (op_class)
          CLS_MEM:    state_nxt = ST_MEM_ADDR;
          CLS_R:      state_nxt = ST_R_EXEC;
          CLS_BRANCH: state_nxt = ST_BRANCH;
          CLS_JUMP:   state_nxt = ST_JUMP;
          CLS_IMM:    state_nxt = ST_I_EXEC;
          default:    state_nxt = ILLEGAL_TRAP ? ST_HALT : ST_FETCH;
        endcase
      end
      ST_MEM_ADDR:  state_nxt = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  if (mem_ready) state_nxt = ST_MEM_WB;
      ST_MEM_WRITE: if (mem_ready) state_nxt = ST_FETCH;
      ST_R_EXEC:    state_nxt = ST_R_WB;
      ST_I_EXEC:    state_nxt = ST_I_WB;
      ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP: state_nxt = ST_FETCH;
      ST_HALT:      state_nxt = ST_HALT;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // State and control-word registers; the control word is decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      ctrl_q <= '0;
    end else begin
      state  <= state_nxt;
      ctrl_q <= state_ctrl(state_nxt, imm_aluop, is_bne, is_jal);
    end
  end

  // Instruction load and PC increment complete together on the fetch handshake
  assign fetch_done     = (state == ST_FETCH) && mem_ready;
  assign ir_write       = fetch_done;
  assign pc_write       = ctrl_q.pc_write | fetch_done;
  assign illegal_op     = (state == ST_DECODE) && !legal;

  assign pc_write_cond  = ctrl_q.pc_write_cond;
  assign pc_write_ncond = ctrl_q.pc_write_ncond;
  assign i_or_d         = ctrl_q.i_or_d;
  assign mem_read       = ctrl_q.mem_read;
  assign mem_write      = ctrl_q.mem_write;
  assign reg_dst        = ctrl_q.reg_dst;
  assign mem_to_reg     = ctrl_q.mem_to_reg;
  assign reg_write      = ctrl_q.reg_write;
  assign alu_src_a      = ctrl_q.alu_src_a;
  assign alu_src_b      = ctrl_q.alu_src_b;
  assign aluop          = ctrl_q.aluop;
  assign pc_source      = ctrl_q.pc_source;
  assign halted         = ctrl_q.halted;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: trapping and non-trapping instances share one stimulus stream.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;

  logic a_pc_write, a_pc_write_cond, a_pc_write_ncond, a_i_or_d, a_mem_read, a_mem_write;
  logic a_ir_write, a_reg_write, a_alu_src_a, a_halted, a_illegal_op;
  logic [1:0] a_reg_dst, a_mem_to_reg, a_alu_src_b, a_pc_source;
  logic [3:0] a_aluop;
  logic b_pc_write, b_pc_write_cond, b_pc_write_ncond, b_i_or_d, b_mem_read, b_mem_write;
  logic b_ir_write, b_reg_write, b_alu_src_a, b_halted, b_illegal_op;
  logic [1:0] b_reg_dst, b_mem_to_reg, b_alu_src_b, b_pc_source;
  logic [3:0] b_aluop;

  mips_multicycle_ctrl #(.ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(a_pc_write), .pc_write_cond(a_pc_write_cond), .pc_write_ncond(a_pc_write_ncond),
    .i_or_d(a_i_or_d), .mem_read(a_mem_read), .mem_write(a_mem_write), .ir_write(a_ir_write),
    .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg), .reg_write(a_reg_write),
    .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .aluop(a_aluop),
    .pc_source(a_pc_source), .halted(a_halted), .illegal_op(a_illegal_op));

  mips_multicycle_ctrl #(.ILLEGAL_TRAP(1'b0)) dut_nt (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond), .pc_write_ncond(b_pc_write_ncond),
    .i_or_d(b_i_or_d), .mem_read(b_mem_read), .mem_write(b_mem_write), .ir_write(b_ir_write),
    .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .aluop(b_aluop),
    .pc_source(b_pc_source), .halted(b_halted), .illegal_op(b_illegal_op));

  always #5 clk = ~clk;

  logic [22:0] va, vb;
  assign va = {a_pc_write, a_pc_write_cond, a_pc_write_ncond, a_i_or_d, a_mem_read, a_mem_write,
               a_ir_write, a_reg_dst, a_mem_to_reg, a_reg_write, a_alu_src_a, a_alu_src_b,
               a_aluop, a_pc_source, a_halted, a_illegal_op};
  assign vb = {b_pc_write, b_pc_write_cond, b_pc_write_ncond, b_i_or_d, b_mem_read, b_mem_write,
               b_ir_write, b_reg_dst, b_mem_to_reg, b_reg_write, b_alu_src_a, b_alu_src_b,
               b_aluop, b_pc_source, b_halted, b_illegal_op};

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each instruction is expanded into a list of step phases
  typedef struct packed {
    bit       wt;      // holds until mem_ready
    bit       fetch;   // ir_write/pc_write follow mem_ready
    bit       sticky;  // left only by reset
    bit       pcw, pcc, pcn, iod, mr, mw;
    bit [1:0] rd, m2r;
    bit       rw, sa;
    bit [1:0] sb;
    bit [3:0] aop;
    bit [1:0] ps;
    bit       h, ill;
  } phase_t;

  phase_t mq [2][$];
  logic [5:0] legal_ops [13] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd10,
                                 6'd12, 6'd13, 6'd14, 6'd15, 6'd35, 6'd43};

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd10, 6'd12, 6'd13,
                      6'd14, 6'd15, 6'd35, 6'd43};
  endfunction

  function automatic int imm_aop(input logic [5:0] op);
    case (op)
      6'd8:  return 0;
      6'd12: return 3;
      6'd15: return 4;
      6'd10: return 5;
      6'd14: return 6;
      6'd13: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic logic [5:0] pick_op();
    if ($urandom_range(7) == 0) return 6'($urandom_range(63));
    return legal_ops[$urandom_range(12)];
  endfunction

  function automatic logic [22:0] expv(input phase_t p, input logic rdy);
    logic fd;
    fd = p.fetch & rdy;
    return {p.pcw | fd, p.pcc, p.pcn, p.iod, p.mr, p.mw, fd, p.rd, p.m2r, p.rw,
            p.sa, p.sb, p.aop, p.ps, p.h, p.ill};
  endfunction

  function automatic phase_t fetch_ph();
    phase_t p;
    p = '0; p.fetch = 1'b1; p.wt = 1'b1; p.mr = 1'b1; p.sb = 2'd1;
    return p;
  endfunction

  task automatic expand(input int k, input logic [5:0] op);
    phase_t p;
    p = '0; p.sb = 2'd3; p.ill = !is_legal(op); mq[k].push_back(p);
    if (op == 6'd35 || op == 6'd43) begin
      p = '0; p.sa = 1'b1; p.sb = 2'd2; mq[k].push_back(p);
      p = '0; p.iod = 1'b1; p.wt = 1'b1;
      if (op == 6'd35) begin
        p.mr = 1'b1; mq[k].push_back(p);
        p = '0; p.rw = 1'b1; p.m2r = 2'd1; mq[k].push_back(p);
      end else begin
        p.mw = 1'b1; mq[k].push_back(p);
      end
    end else if (op == 6'd0) begin
      p = '0; p.sa = 1'b1; p.aop = 4'd2; mq[k].push_back(p);
      p = '0; p.rw = 1'b1; p.rd = 2'd1; mq[k].push_back(p);
    end else if (imm_aop(op) >= 0) begin
      p = '0; p.sa = 1'b1; p.sb = 2'd2; p.aop = 4'(imm_aop(op)); mq[k].push_back(p);
      p = '0; p.rw = 1'b1; mq[k].push_back(p);
    end else if (op == 6'd4 || op == 6'd5) begin
      p = '0; p.sa = 1'b1; p.aop = 4'd1; p.ps = 2'd1;
      p.pcc = (op == 6'd4); p.pcn = (op == 6'd5); mq[k].push_back(p);
    end else if (op == 6'd2 || op == 6'd3) begin
      p = '0; p.pcw = 1'b1; p.ps = 2'd2;
      if (op == 6'd3) begin p.rw = 1'b1; p.rd = 2'd2; p.m2r = 2'd2; end
      mq[k].push_back(p);
    end else if (k == 0) begin
      p = '0; p.h = 1'b1; p.sticky = 1'b1; mq[k].push_back(p);
    end
  endtask

  task automatic advance(input int k);
    phase_t f;
    if (rst) begin
      mq[k].delete();
      mq[k].push_back(phase_t'('0));
      return;
    end
    f = mq[k][0];
    if (f.sticky || (f.wt && !mem_ready)) return;
    void'(mq[k].pop_front());
    if (f.fetch) expand(k, opcode);
    if (mq[k].size() == 0) mq[k].push_back(fetch_ph());
  endtask

  typedef struct {
    logic [5:0] op;
    int lat, rw, mw, mr, pcw, irw;
    logic [3:0] aop3;
  } vec_t;
  vec_t tbl [13];

  initial begin
    int n_rw, n_mw, n_mr, n_pcw, n_irw, n_bad, n_wr, n_ill;
    logic [3:0] aop3;

    // opcode, latency, reg_write/mem_write/mem_read/pc_write/ir_write cycles, aluop in 3rd cycle
    tbl[0]  = '{6'd35, 5, 1, 0, 2, 1, 1, 4'd0};
    tbl[1]  = '{6'd43, 4, 0, 1, 1, 1, 1, 4'd0};
    tbl[2]  = '{6'd0,  4, 1, 0, 1, 1, 1, 4'd2};
    tbl[3]  = '{6'd8,  4, 1, 0, 1, 1, 1, 4'd0};
    tbl[4]  = '{6'd10, 4, 1, 0, 1, 1, 1, 4'd5};
    tbl[5]  = '{6'd12, 4, 1, 0, 1, 1, 1, 4'd3};
    tbl[6]  = '{6'd13, 4, 1, 0, 1, 1, 1, 4'd7};
    tbl[7]  = '{6'd14, 4, 1, 0, 1, 1, 1, 4'd6};
    tbl[8]  = '{6'd15, 4, 1, 0, 1, 1, 1, 4'd4};
    tbl[9]  = '{6'd4,  3, 0, 0, 1, 1, 1, 4'd1};
    tbl[10] = '{6'd5,  3, 0, 0, 1, 1, 1, 4'd1};
    tbl[11] = '{6'd2,  3, 0, 0, 1, 2, 1, 4'd0};
    tbl[12] = '{6'd3,  3, 1, 0, 1, 2, 1, 4'd0};

    rst = 1'b1; mem_ready = 1'b1; opcode = 6'd0;
    step(); step();
    chk("reset_trap", 32'(va), 32'd0);
    chk("reset_notrap", 32'(vb), 32'd0);
    rst = 1'b0;
    step();
    chk("first_fetch", 32'({a_mem_read, a_alu_src_b, a_ir_write}), 32'b1_01_1);

    // Latency and per-instruction strobe counts with memory always ready
    for (int e = 0; e < 13; e++) begin
      opcode = tbl[e].op;
      n_rw = 0; n_mw = 0; n_mr = 0; n_pcw = 0; n_irw = 0; aop3 = 4'hx;
      for (int c = 0; c < tbl[e].lat; c++) begin
        @(negedge clk);
        n_rw += int'(a_reg_write); n_mw += int'(a_mem_write); n_mr += int'(a_mem_read);
        n_pcw += int'(a_pc_write); n_irw += int'(a_ir_write);
        if (c == 2) aop3 = a_aluop;
        step();
      end
      chk($sformatf("op%0d_reg_write", tbl[e].op), 32'(n_rw), 32'(tbl[e].rw));
      chk($sformatf("op%0d_mem_write", tbl[e].op), 32'(n_mw), 32'(tbl[e].mw));
      chk($sformatf("op%0d_mem_read", tbl[e].op), 32'(n_mr), 32'(tbl[e].mr));
      chk($sformatf("op%0d_pc_write", tbl[e].op), 32'(n_pcw), 32'(tbl[e].pcw));
      chk($sformatf("op%0d_ir_write", tbl[e].op), 32'(n_irw), 32'(tbl[e].irw));
      chk($sformatf("op%0d_aluop", tbl[e].op), 32'(aop3), 32'(tbl[e].aop3));
      chk($sformatf("op%0d_back_to_fetch", tbl[e].op),
          32'({a_mem_read, a_alu_src_b, a_i_or_d}), 32'b1_01_0);
    end

    // Reset held two cycles while lw waits on memory
    opcode = 6'd35;
    step(); step();
    mem_ready = 1'b0;
    step();
    chk("lw_wait_1", 32'({a_mem_read, a_i_or_d, a_mem_write}), 32'b110);
    step();
    chk("lw_wait_2", 32'({a_mem_read, a_i_or_d, a_mem_write}), 32'b110);
    rst = 1'b1;
    step(); step();
    chk("rst_mid_read", 32'(va), 32'd0);
    rst = 1'b0;
    step();
    chk("fetch_after_rst", 32'({a_mem_read, a_ir_write, a_pc_write}), 32'b100);

    // sw with memory stalling three cycles
    opcode = 6'd43; mem_ready = 1'b1;
    #1;
    chk("fetch_ready_strobes", 32'({a_ir_write, a_pc_write}), 32'b11);
    step(); step();
    mem_ready = 1'b0;
    step();
    n_mw = 0; n_rw = 0; n_mr = 0;
    for (int j = 0; j < 4; j++) begin
      mem_ready = (j == 3);
      #1;
      n_mw += int'(a_mem_write & a_i_or_d); n_rw += int'(a_reg_write); n_mr += int'(a_mem_read);
      step();
    end
    chk("sw_stall_mem_write", 32'(n_mw), 32'd4);
    chk("sw_stall_reg_write", 32'(n_rw), 32'd0);
    chk("sw_stall_no_read", 32'(n_mr), 32'd0);
    chk("sw_then_fetch", 32'({a_mem_read, a_alu_src_b}), 32'b1_01);

    // Unknown opcode: trap instance halts, non-trap instance refetches
    opcode = 6'd63;
    step();
    chk("illegal_pulse_trap", 32'(a_illegal_op), 32'd1);
    chk("illegal_pulse_notrap", 32'(b_illegal_op), 32'd1);
    step();
    chk("halt_entered", 32'(va), 32'h2);
    chk("notrap_refetch", 32'({b_mem_read, b_halted, b_illegal_op}), 32'b100);
    n_bad = 0; n_wr = 0; n_ill = 0;
    for (int j = 0; j < 20; j++) begin
      mem_ready = 1'($urandom_range(1));
      #1;
      if (va !== 23'h2) n_bad++;
      n_wr += int'(b_reg_write | b_mem_write);
      n_ill += int'(a_illegal_op);
      step();
    end
    chk("halt_sticky", 32'(n_bad), 32'd0);
    chk("halt_no_repulse", 32'(n_ill), 32'd0);
    chk("notrap_no_writes", 32'(n_wr), 32'd0);
    rst = 1'b1;
    step();
    chk("halt_cleared_by_rst", 32'(a_halted), 32'd0);

    // Randomized traffic against the phase-list model
    rst = 1'b0; opcode = 6'd0; mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mq[k].push_back(phase_t'('0));
    end
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      chk("rand_trap", 32'(va), 32'(expv(mq[0][0], mem_ready)));
      chk("rand_notrap", 32'(vb), 32'(expv(mq[1][0], mem_ready)));
      advance(0);
      advance(1);
      step();
      rst = ($urandom_range(63) == 0);
      mem_ready = ($urandom_range(9) < 7);
      if (mq[1][0].fetch) opcode = pick_op();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
